megarom_bank_ctrl: RTL and testbench

- Bank-switch controller for the cartridge ROM address datapath. Watches MSX slot write cycles and keeps four 8 KB window bank registers. Drives ROM bank address bits ROMA[18:13] and the gated ROM output enable.
- Supports four MegaROM mapper types, chosen by SW[1:0] once after reset.
- Sits between the slot bus pins and the external flash/ROM, replacing a fixed-type mapper.

---
 rtl/megarom_pkg.sv | 26 ++
 rtl/megarom_decode.sv | 58 +++++
 rtl/megarom_bank_ctrl.sv | 147 ++++++++++++++
 tb/tb_megarom_bank_ctrl.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/megarom_pkg.sv
// rtl/megarom_pkg.sv - shared types and constants for the MegaROM bank controller
// Contents: mapper type encodings, FSM state encoding, window reset banks.
package megarom_pkg;

  typedef enum logic [1:0] {
    MT_KONAMI  = 2'd0,
    MT_SCC     = 2'd1,
    MT_ASCII8  = 2'd2,
    MT_ASCII16 = 2'd3
  } map_type_t;

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_CAPTURE,
    S_COMMIT,
    S_WAIT_RELEASE
  } state_t;

  // Windows come out of reset mapping banks 0..3 in order.
  localparam logic [5:0] WIN0_RST = 6'd0;
  localparam logic [5:0] WIN1_RST = 6'd1;
  localparam logic [5:0] WIN2_RST = 6'd2;
  localparam logic [5:0] WIN3_RST = 6'd3;

endpackage

// File: rtl/megarom_decode.sv
// rtl/megarom_decode.sv - bank register write decode per mapper type
// Ports:
//   map_type  in   latched mapper type
//   a         in   registered address A[15:11]
//   hit       out  address selects a bank register
//   idx       out  target window (pair writes: first of the pair)
//   pair      out  write loads win[idx]=2N and win[idx+1]=2N+1
module megarom_decode
  import megarom_pkg::*;
(
  input  map_type_t   map_type,
  input  logic [4:0]  a,
  output logic        hit,
  output logic [1:0]  idx,
  output logic        pair
);

  always_comb begin
    hit  = 1'b0;
    idx  = 2'd0;
    pair = 1'b0;
    case (map_type)
      MT_KONAMI: begin
        // Only 8 KB granularity matters; win0 is hard-wired to bank 0.
        case (a[4:2])
          3'b011:  begin hit = 1'b1; idx = 2'd1; end
          3'b100:  begin hit = 1'b1; idx = 2'd2; end
          3'b101:  begin hit = 1'b1; idx = 2'd3; end
          default: ;
        endcase
      end
      MT_SCC: begin
        case (a)
          5'h0A:   begin hit = 1'b1; idx = 2'd0; end
          5'h0E:   begin hit = 1'b1; idx = 2'd1; end
          5'h12:   begin hit = 1'b1; idx = 2'd2; end
          5'h16:   begin hit = 1'b1; idx = 2'd3; end
          default: ;
        endcase
      end
      MT_ASCII8: begin
        // 6000/6800/7000/7800 map straight onto A[12:11].
        if (a[4:2] == 3'b011) begin
          hit = 1'b1;
          idx = a[1:0];
        end
      end
      default: begin
        if (a == 5'h0C) begin
          hit = 1'b1; idx = 2'd0; pair = 1'b1;
        end else if (a == 5'h0E) begin
          hit = 1'b1; idx = 2'd2; pair = 1'b1;
        end
      end
    endcase
  end

endmodule

// File: rtl/megarom_bank_ctrl.sv
// rtl/megarom_bank_ctrl.sv - MSX MegaROM bank-switch controller
// Ports:
//   SLOTCLK  in   slot clock
//   RESET    in   async active-low reset
//   A        in   address A[15:11]
//   D        in   write data
//   RD, WR, MREQ, EXSLTSL  in  active-low bus strobes
//   SW       in   mapper type select, sampled once after reset
//   ROMA     out  ROM address [18:13]
//   ROMOE    out  active-low ROM output enable
//   MAP_TYPE out  latched mapper type
//   BUSY     out  high during CAPTURE/COMMIT
module megarom_bank_ctrl
  import megarom_pkg::*;
#(
  parameter int BANK_BITS = 6
) (
  input  logic        SLOTCLK,
  input  logic        RESET,
  input  logic [4:0]  A,
  input  logic [7:0]  D,
  input  logic        RD,
  input  logic        WR,
  input  logic        MREQ,
  input  logic        EXSLTSL,
  input  logic [1:0]  SW,
  output logic [5:0]  ROMA,
  output logic        ROMOE,
  output logic [1:0]  MAP_TYPE,
  output logic        BUSY
);

  logic [4:0] a_q;
  logic [7:0] d_q;
  logic       wr_q, mreq_q, sltsl_q;

  state_t     state;
  map_type_t  map_type;
  logic [1:0] cap_idx;
  logic [7:0] cap_d;
  logic       cap_pair;
  logic       busy;
  logic [BANK_BITS-1:0] win [4];

  logic       dec_hit, dec_pair;
  logic [1:0] dec_idx;
  logic       strobe;
  logic [BANK_BITS-1:0] val_single, val_even, val_odd;

  // Single input register stage; the FSM only ever sees these copies.
  always_ff @(posedge SLOTCLK or negedge RESET) begin
    if (!RESET) begin
      a_q     <= '0;
      d_q     <= '0;
      wr_q    <= 1'b1;
      mreq_q  <= 1'b1;
      sltsl_q <= 1'b1;
    end else begin
      a_q     <= A;
      d_q     <= D;
      wr_q    <= WR;
      mreq_q  <= MREQ;
      sltsl_q <= EXSLTSL;
    end
  end

  assign strobe = ~mreq_q & ~wr_q & ~sltsl_q;

  megarom_decode u_decode (
    .map_type (map_type),
    .a        (a_q),
    .hit      (dec_hit),
    .idx      (dec_idx),
    .pair     (dec_pair)
  );

  // 2N keeps its low bit clear after truncation, so 2N+1 is just bit 0 set.
  assign val_single = BANK_BITS'(cap_d);
  assign val_even   = BANK_BITS'({cap_d, 1'b0});
  assign val_odd    = val_even | BANK_BITS'(1);

  always_ff @(posedge SLOTCLK or negedge RESET) begin
    if (!RESET) begin
      state    <= S_INIT;
      map_type <= MT_KONAMI;
      cap_idx  <= '0;
      cap_d    <= '0;
      cap_pair <= 1'b0;
      busy     <= 1'b0;
      win[0]   <= BANK_BITS'(WIN0_RST);
      win[1]   <= BANK_BITS'(WIN1_RST);
      win[2]   <= BANK_BITS'(WIN2_RST);
      win[3]   <= BANK_BITS'(WIN3_RST);
    end else begin
      case (state)
        S_INIT: begin
          map_type <= map_type_t'(SW);
          state    <= S_IDLE;
        end
        S_IDLE: begin
          if (strobe) begin
            if (dec_hit) begin
              cap_idx  <= dec_idx;
              cap_d    <= d_q;
              cap_pair <= dec_pair;
              busy     <= 1'b1;
              state    <= S_CAPTURE;
            end else begin
              state <= S_WAIT_RELEASE;
            end
          end
        end
        S_CAPTURE: state <= S_COMMIT;
        S_COMMIT: begin
          if (cap_pair) begin
            win[cap_idx]              <= val_even;
            win[{cap_idx[1], 1'b1}]   <= val_odd;
          end else begin
            win[cap_idx] <= val_single;
          end
          busy  <= 1'b0;
          state <= S_WAIT_RELEASE;
        end
        // Holding WR low must not retrigger a second commit.
        S_WAIT_RELEASE: if (wr_q) state <= S_IDLE;
        default: state <= S_INIT;
      endcase
    end
  end

  assign MAP_TYPE = map_type;
  assign BUSY     = busy;

  // Read path works from live pins so ROM timing is not delayed by a clock.
  always_comb begin
    ROMA  = 6'd0;
    ROMOE = 1'b1;
    case (A[4:2])
      3'b010: begin ROMA = 6'(win[0]); ROMOE = MREQ | RD | EXSLTSL; end
      3'b011: begin ROMA = 6'(win[1]); ROMOE = MREQ | RD | EXSLTSL; end
      3'b100: begin ROMA = 6'(win[2]); ROMOE = MREQ | RD | EXSLTSL; end
      3'b101: begin ROMA = 6'(win[3]); ROMOE = MREQ | RD | EXSLTSL; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_megarom_bank_ctrl.sv
// tb/tb_megarom_bank_ctrl.sv - self-checking bench for megarom_bank_ctrl
module tb_megarom_bank_ctrl;
  import megarom_pkg::*;

  logic       SLOTCLK = 1'b0;
  logic       RESET   = 1'b0;
  logic [4:0] A       = '0;
  logic [7:0] D       = '0;
  logic       RD = 1'b1, WR = 1'b1, MREQ = 1'b1, EXSLTSL = 1'b1;
  logic [1:0] SW      = '0;
  logic [5:0] ROMA;
  logic       ROMOE;
  logic [1:0] MAP_TYPE;
  logic       BUSY;

  megarom_bank_ctrl #(.BANK_BITS(6)) dut (
    .SLOTCLK  (SLOTCLK),
    .RESET    (RESET),
    .A        (A),
    .D        (D),
    .RD       (RD),
    .WR       (WR),
    .MREQ     (MREQ),
    .EXSLTSL  (EXSLTSL),
    .SW       (SW),
    .ROMA     (ROMA),
    .ROMOE    (ROMOE),
    .MAP_TYPE (MAP_TYPE),
    .BUSY     (BUSY)
  );

  always #5 SLOTCLK = ~SLOTCLK;

  int cyc = 0;
  always @(posedge SLOTCLK) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         phase;
    logic [4:0] a;
    logic       mreq, rd, sl;
    logic [5:0] roma;
    logic       oe;
  } vec_t;
  vec_t vecs[$];

  typedef struct {
    int         idx;
    logic [5:0] val;
    int         due;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input int p, input logic [4:0] a, input logic mreq, input logic rd,
                      input logic sl, input logic [5:0] roma, input logic oe);
    vec_t v;
    v.phase = p; v.a = a; v.mreq = mreq; v.rd = rd; v.sl = sl; v.roma = roma; v.oe = oe;
    vecs.push_back(v);
  endtask

  task automatic expect_commit(input int idx, input logic [5:0] val);
    exp_t e;
    e.idx = idx; e.val = val; e.due = cyc + 4;
    sb.push_back(e);
  endtask

  // Every bank register change must match the head of the scoreboard,
  // including the edge on which it lands.
  logic [5:0] prev [4];
  always @(negedge SLOTCLK) begin
    logic [5:0] cur;
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      cur = dut.win[i];
      if (!RESET) begin
        prev[i] = cur;
      end else if (cur !== prev[i]) begin
        if (sb.size() == 0) begin
          chk($sformatf("unexpected_commit_win%0d", i), cur, prev[i]);
        end else begin
          e = sb.pop_front();
          chk("commit_idx", i, e.idx);
          chk($sformatf("commit_val_win%0d", i), cur, e.val);
          chk($sformatf("commit_cycle_win%0d", i), cyc, e.due);
        end
        prev[i] = cur;
      end
    end
  end

  task automatic idle_pins();
    A = '0; D = '0; RD = 1'b1; WR = 1'b1; MREQ = 1'b1; EXSLTSL = 1'b1;
  endtask

  task automatic do_reset(input logic [1:0] sw);
    @(negedge SLOTCLK);
    RESET = 1'b0;
    SW = sw;
    idle_pins();
    repeat (2) @(negedge SLOTCLK);
    RESET = 1'b1;
    repeat (3) @(negedge SLOTCLK);
  endtask

  task automatic do_write(input logic [4:0] a, input logic [7:0] d, input int hold,
                          output int busy_cnt);
    A = a; D = d; MREQ = 1'b0; EXSLTSL = 1'b0; WR = 1'b0;
    busy_cnt = 0;
    for (int k = 1; k <= hold + 6; k++) begin
      @(negedge SLOTCLK);
      if (BUSY) busy_cnt++;
      if (k == hold) begin
        WR = 1'b1; MREQ = 1'b1; EXSLTSL = 1'b1;
      end
    end
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        @(negedge SLOTCLK);
        A = vecs[i].a; MREQ = vecs[i].mreq; RD = vecs[i].rd; EXSLTSL = vecs[i].sl;
        #1;
        chk($sformatf("read_p%0d_a%02h_roma", p, vecs[i].a), ROMA, vecs[i].roma);
        chk($sformatf("read_p%0d_a%02h_oe", p, vecs[i].a), ROMOE, vecs[i].oe);
      end
    end
    @(negedge SLOTCLK);
    idle_pins();
  endtask

  initial begin
    int b;

    // phase 0: reset values, ASCII8 selected
    addv(0, 5'h08, 0, 0, 0, 6'h00, 0);
    addv(0, 5'h0C, 0, 0, 0, 6'h01, 0);
    addv(0, 5'h10, 0, 0, 0, 6'h02, 0);
    addv(0, 5'h14, 0, 0, 0, 6'h03, 0);
    addv(0, 5'h08, 0, 1, 0, 6'h00, 1);
    addv(0, 5'h10, 1, 0, 0, 6'h02, 1);
    addv(0, 5'h14, 0, 0, 1, 6'h03, 1);
    // phase 1: after ASCII8 write to 7000h
    addv(1, 5'h10, 0, 0, 0, 6'h2A, 0);
    // phase 2: ASCII16 pair writes
    addv(2, 5'h08, 0, 0, 0, 6'h0A, 0);
    addv(2, 5'h0C, 0, 0, 0, 6'h0B, 0);
    addv(2, 5'h10, 0, 0, 0, 6'h3E, 0);
    addv(2, 5'h14, 0, 0, 0, 6'h3F, 0);
    // phase 3: KONAMI
    addv(3, 5'h08, 0, 0, 0, 6'h00, 0);
    addv(3, 5'h0C, 0, 0, 0, 6'h01, 0);
    addv(3, 5'h10, 0, 0, 0, 6'h02, 0);
    addv(3, 5'h14, 0, 0, 0, 6'h07, 0);
    // phase 4: KONAMI_SCC, 9800h reads plain ROM
    addv(4, 5'h10, 0, 0, 0, 6'h09, 0);
    addv(4, 5'h13, 0, 0, 0, 6'h09, 0);
    addv(4, 5'h0A, 0, 0, 0, 6'h00, 0);
    addv(4, 5'h0E, 0, 0, 0, 6'h01, 0);
    // phase 5: after reset during CAPTURE, plus out-of-range reads
    addv(5, 5'h08, 0, 0, 0, 6'h00, 0);
    addv(5, 5'h0C, 0, 0, 0, 6'h01, 0);
    addv(5, 5'h00, 0, 0, 0, 6'h00, 1);
    addv(5, 5'h18, 0, 0, 0, 6'h00, 1);

    do_reset(2'b10);
    chk("reset_map_type", MAP_TYPE, 2'b10);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_state_idle", dut.state, S_IDLE);
    run_phase(0);

    expect_commit(2, 6'h2A);
    do_write(5'h0E, 8'h2A, 2, b);
    chk("ascii8_busy_cycles", b, 2);
    run_phase(1);

    do_reset(2'b11);
    expect_commit(0, 6'h0A);
    expect_commit(1, 6'h0B);
    do_write(5'h0C, 8'h25, 2, b);
    expect_commit(2, 6'h3E);
    expect_commit(3, 6'h3F);
    do_write(5'h0E, 8'h1F, 2, b);
    run_phase(2);

    do_reset(2'b00);
    do_write(5'h08, 8'h05, 2, b);
    chk("konami_win0_busy", b, 0);
    chk("konami_win0_fixed", dut.win[0], 6'h00);
    expect_commit(3, 6'h07);
    do_write(5'h14, 8'h07, 10, b);
    chk("konami_long_wr_busy", b, 2);
    chk("konami_back_to_idle", dut.state, S_IDLE);
    run_phase(3);

    do_reset(2'b01);
    expect_commit(2, 6'h09);
    do_write(5'h12, 8'h09, 2, b);
    do_write(5'h13, 8'h33, 2, b);
    chk("scc_9800_busy", b, 0);
    SW = 2'b11;
    repeat (3) @(negedge SLOTCLK);
    chk("scc_sw_change_ignored", MAP_TYPE, 2'b01);
    run_phase(4);

    do_reset(2'b10);
    expect_commit(1, 6'h15);
    do_write(5'h0D, 8'h15, 2, b);
    A = 5'h0C; D = 8'h11; MREQ = 1'b0; EXSLTSL = 1'b0; WR = 1'b0;
    repeat (2) @(negedge SLOTCLK);
    chk("rst_mid_busy_in_capture", BUSY, 1'b1);
    RESET = 1'b0;
    #1;
    chk("rst_mid_win0", dut.win[0], 6'h00);
    chk("rst_mid_win1", dut.win[1], 6'h01);
    chk("rst_mid_win2", dut.win[2], 6'h02);
    chk("rst_mid_win3", dut.win[3], 6'h03);
    chk("rst_mid_busy", BUSY, 1'b0);
    @(negedge SLOTCLK);
    idle_pins();
    @(negedge SLOTCLK);
    RESET = 1'b1;
    repeat (8) @(negedge SLOTCLK);
    run_phase(5);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
